// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master
// Description : Single-clock Clause 22 MDIO management master. Accepts
//               read/write commands on a valid/ready interface, serialises
//               the frame on MDC/MDIO and returns a one-cycle response pulse
//               carrying read data and the turnaround error flag.
//               Optional feature macro: MDIO_PRE_SUPPRESS_EN (adds the
//               cfg_pre_skip input that drops the 32-bit preamble).
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_ta_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
`ifdef MDIO_PRE_SUPPRESS_EN
    input  logic        cfg_pre_skip,
`endif
    input  logic        mdio_in
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_pre  = 3'd1;
    localparam logic [2:0] c_st_hdr  = 3'd2;
    localparam logic [2:0] c_st_ta   = 3'd3;
    localparam logic [2:0] c_st_data = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    localparam logic [7:0] c_div_reload = 8'(CLK_DIV - 1);

    logic [2:0]  r_state;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_div_cnt;
    logic        r_mdc;
    logic        r_mdio_out;
    logic        r_mdio_oe;
    logic        r_rd;
    logic [31:0] r_tx;
    logic [15:0] r_rx;
    logic        r_ta_bad;
    logic [15:0] r_rdata;
    logic        r_ta_err;

    logic        w_pre_skip;
    logic [31:0] w_frame;
    logic        w_tick;
    logic [2:0]  w_nxt_state;
    logic [4:0]  w_nxt_cnt;

`ifdef MDIO_PRE_SUPPRESS_EN
    assign w_pre_skip = cfg_pre_skip;
`else
    assign w_pre_skip = 1'b0;
`endif

    // Everything after the preamble as one word; read TA/DATA slots are
    // placeholders since the pad is released for those bits.
    assign w_frame = {2'b01,
                      cmd_rd ? 2'b10 : 2'b01,
                      cmd_phyad,
                      cmd_regad,
                      cmd_rd ? 2'b11 : 2'b10,
                      cmd_rd ? 16'hFFFF : cmd_wdata};

    assign w_tick = (r_div_cnt == 8'd0);

    // Field sequencing: next state and bit count at the end of the current bit
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_bit_cnt - 5'd1;
        if (r_bit_cnt == 5'd0) begin
            case (r_state)
                c_st_pre: begin w_nxt_state = c_st_hdr;  w_nxt_cnt = 5'd13; end
                c_st_hdr: begin w_nxt_state = c_st_ta;   w_nxt_cnt = 5'd1;  end
                c_st_ta:  begin w_nxt_state = c_st_data; w_nxt_cnt = 5'd15; end
                default:  begin w_nxt_state = c_st_done; w_nxt_cnt = 5'd0;  end
            endcase
        end
    end

    // Frame engine: MDC divider, bit shifting, input sampling and response capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_st_idle;
            r_bit_cnt  <= 5'd0;
            r_div_cnt  <= 8'd0;
            r_mdc      <= 1'b0;
            r_mdio_out <= 1'b1;
            r_mdio_oe  <= 1'b0;
            r_rd       <= 1'b0;
            r_tx       <= 32'd0;
            r_rx       <= 16'd0;
            r_ta_bad   <= 1'b0;
            r_rdata    <= 16'd0;
            r_ta_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_rd      <= cmd_rd;
                        r_div_cnt <= c_div_reload;
                        r_mdc     <= 1'b0;
                        r_mdio_oe <= 1'b1;
                        if (w_pre_skip) begin
                            r_state    <= c_st_hdr;
                            r_bit_cnt  <= 5'd13;
                            r_mdio_out <= w_frame[31];
                            r_tx       <= {w_frame[30:0], 1'b1};
                        end else begin
                            r_state    <= c_st_pre;
                            r_bit_cnt  <= 5'd31;
                            r_mdio_out <= 1'b1;
                            r_tx       <= w_frame;
                        end
                    end
                end
                c_st_pre, c_st_hdr, c_st_ta, c_st_data: begin
                    if (!w_tick) begin
                        r_div_cnt <= r_div_cnt - 8'd1;
                    end else begin
                        r_div_cnt <= c_div_reload;
                        if (!r_mdc) begin
                            // Rising MDC: sample the PHY
                            r_mdc <= 1'b1;
                            if (r_state == c_st_ta && r_bit_cnt == 5'd0)
                                r_ta_bad <= mdio_in;
                            if (r_state == c_st_data)
                                r_rx <= {r_rx[14:0], mdio_in};
                        end else begin
                            // Falling MDC: start of the next bit
                            r_mdc     <= 1'b0;
                            r_state   <= w_nxt_state;
                            r_bit_cnt <= w_nxt_cnt;
                            if (w_nxt_state == c_st_done) begin
                                r_mdio_oe  <= 1'b0;
                                r_mdio_out <= 1'b1;
                                r_rdata    <= r_rd ? r_rx : 16'd0;
                                r_ta_err   <= r_rd & r_ta_bad;
                            end else if (w_nxt_state == c_st_pre) begin
                                r_mdio_out <= 1'b1;
                            end else begin
                                r_mdio_out <= r_tx[31];
                                r_tx       <= {r_tx[30:0], 1'b1};
                                r_mdio_oe  <= !(r_rd && (w_nxt_state == c_st_ta ||
                                                         w_nxt_state == c_st_data));
                            end
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign cmd_ready  = (r_state == c_st_idle);
    assign busy       = (r_state != c_st_idle);
    assign rsp_valid  = (r_state == c_st_done);
    assign rsp_rdata  = r_rdata;
    assign rsp_ta_err = r_ta_err;
    assign mdc        = r_mdc;
    assign mdio_out   = r_mdio_out;
    assign mdio_oe    = r_mdio_oe;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_master
// Description : Self-checking bench for mdio_master. Commands push expected
//               responses to a scoreboard; a monitor captures the MDIO bit
//               stream at MDC rise, plays the PHY, and checks each response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

    localparam int CLK_DIV = 10;

    typedef struct {
        logic        rd;
        logic        resp;
        logic [15:0] pd;
        logic [15:0] rdata;
        logic        ta_err;
        int          nbits;
        logic [63:0] stream;
        logic [63:0] oe;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_ta_err;
    logic        busy;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;
    logic        cfg_pre_skip;

    exp_t        sb[$];
    int          acc_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rsp = 0;
    int          n_exp_rsp = 0;
    int          last_rsp_cyc = 0;
    int          last_acc_cyc = 0;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rd     (cmd_rd),
        .cmd_phyad  (cmd_phyad),
        .cmd_regad  (cmd_regad),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_ta_err (rsp_ta_err),
        .busy       (busy),
        .mdc        (mdc),
        .mdio_out   (mdio_out),
        .mdio_oe    (mdio_oe),
`ifdef MDIO_PRE_SUPPRESS_EN
        .cfg_pre_skip (cfg_pre_skip),
`endif
        .mdio_in    (mdio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                                    input logic [15:0] wd, input logic resp, input logic [15:0] pd,
                                    input logic skip);
        exp_t        e;
        logic [31:0] f;
        logic [31:0] o;
        f = {2'b01, rd ? 2'b10 : 2'b01, pa, ra, rd ? 2'b00 : 2'b10, rd ? 16'h0000 : wd};
        o = rd ? {14'h3FFF, 18'h00000} : 32'hFFFF_FFFF;
        e.rd     = rd;
        e.resp   = resp;
        e.pd     = pd;
        e.rdata  = rd ? (resp ? pd : 16'hFFFF) : 16'h0000;
        e.ta_err = rd & !resp;
        e.nbits  = skip ? 32 : 64;
        e.stream = skip ? {32'h0, f} : {32'hFFFF_FFFF, f};
        e.oe     = skip ? {32'h0, o} : {32'hFFFF_FFFF, o};
        return e;
    endfunction

    // Monitor: stream capture, PHY model, accept logging and response checks
    initial begin
        logic [63:0] cap_out;
        logic [63:0] cap_oe;
        int          rise_cnt;
        logic        prev_mdc;
        exp_t        e;
        int          acc;
        int          p;
        cap_out  = '0;
        cap_oe   = '0;
        rise_cnt = 0;
        prev_mdc = 1'b0;
        mdio_in  = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cap_out  = '0;
                cap_oe   = '0;
                rise_cnt = 0;
                mdio_in  = 1'b1;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    acc_q.push_back(cyc);
                    last_acc_cyc = cyc;
                end
                if (mdc && !prev_mdc) begin
                    cap_out = {cap_out[62:0], mdio_out};
                    cap_oe  = {cap_oe[62:0], mdio_oe};
                    rise_cnt++;
                end
                if (rsp_valid) begin
                    n_rsp++;
                    last_rsp_cyc = cyc;
                    if (sb.size() == 0 || acc_q.size() == 0) begin
                        check_value("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e   = sb.pop_front();
                        acc = acc_q.pop_front();
                        check_value("rsp_latency", 64'(cyc), 64'(acc + 1 + 2 * CLK_DIV * e.nbits));
                        check_value("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        check_value("rsp_ta_err", 64'(rsp_ta_err), 64'(e.ta_err));
                        check_value("frame_bits", 64'(rise_cnt), 64'(e.nbits));
                        check_value("mdio_stream", cap_out & e.oe, e.stream & e.oe);
                        check_value("mdio_oe_stream", cap_oe, e.oe);
                        check_value("done_mdc_oe", {62'd0, mdc, mdio_oe}, 64'd0);
                    end
                    cap_out  = '0;
                    cap_oe   = '0;
                    rise_cnt = 0;
                end
                // PHY drives its bit during the MDC low phase
                mdio_in = 1'b1;
                if (busy && !mdc && sb.size() != 0) begin
                    e = sb[0];
                    p = rise_cnt - (e.nbits - 32);
                    if (e.rd && e.resp) begin
                        if (p == 15)
                            mdio_in = 1'b0;
                        else if (p >= 16 && p <= 31)
                            mdio_in = e.pd[31 - p];
                    end
                end
            end
            prev_mdc = mdc;
        end
    end

    // Issue one command and wait for acceptance; cmd_valid is left high
    task automatic send(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic resp, input logic [15:0] pd,
                        input logic skip);
        int n;
        cmd_valid    = 1'b1;
        cmd_rd       = rd;
        cmd_phyad    = pa;
        cmd_regad    = ra;
        cmd_wdata    = wd;
        cfg_pre_skip = skip;
        sb.push_back(mk_exp(rd, pa, ra, wd, resp, pd, skip));
        n_exp_rsp++;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check_value("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_value("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
            acc_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn         = 1'b0;
        cmd_valid    = 1'b0;
        cmd_rd       = 1'b0;
        cmd_phyad    = 5'd0;
        cmd_regad    = 5'd0;
        cmd_wdata    = 16'd0;
        cfg_pre_skip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_value("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check_value("rst_rsp_ta_err", 64'(rsp_ta_err), 64'd0);
        check_value("rst_mdc", 64'(mdc), 64'd0);
        check_value("rst_mdio_out", 64'(mdio_out), 64'd1);
        check_value("rst_mdio_oe", 64'(mdio_oe), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Write frame with known bit pattern
        send(1'b0, 5'h01, 5'h05, 16'hA5C3, 1'b0, 16'h0000, 1'b0);
        cmd_valid = 1'b0;
        check_value("accept_busy", 64'(busy), 64'd1);
        check_value("accept_ready", 64'(cmd_ready), 64'd0);
        wait_done();
        check_value("idle_mdc_oe", {62'd0, mdc, mdio_oe}, 64'd0);

        // Read with a responding PHY
        send(1'b1, 5'h1F, 5'h02, 16'h0000, 1'b1, 16'h1234, 1'b0);
        cmd_valid = 1'b0;
        wait_done();
        check_value("rdata_held", 64'(rsp_rdata), 64'h1234);

        // Read with no PHY present
        send(1'b1, 5'h0A, 5'h11, 16'h0000, 1'b0, 16'h0000, 1'b0);
        cmd_valid = 1'b0;
        wait_done();

        // Back-to-back with cmd_valid held high
        send(1'b0, 5'h03, 5'h07, 16'h0F0F, 1'b0, 16'h0000, 1'b0);
        send(1'b1, 5'h04, 5'h09, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
        cmd_valid = 1'b0;
        check_value("b2b_accept_cycle", 64'(last_acc_cyc), 64'(last_rsp_cyc + 1));
        wait_done();

        // Reset in the middle of HDR bit 5
        send(1'b1, 5'h02, 5'h03, 16'h0000, 1'b1, 16'h5555, 1'b0);
        cmd_valid = 1'b0;
        repeat (2 * CLK_DIV * 36 + 5) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_value("abort_mdc", 64'(mdc), 64'd0);
        check_value("abort_mdio_oe", 64'(mdio_oe), 64'd0);
        check_value("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check_value("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        sb.delete();
        acc_q.delete();
        n_exp_rsp--;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(1'b0, 5'h15, 5'h0C, 16'h3C96, 1'b0, 16'h0000, 1'b0);
        cmd_valid = 1'b0;
        wait_done();

`ifdef MDIO_PRE_SUPPRESS_EN
        // Preamble suppression on and off
        send(1'b0, 5'h06, 5'h1A, 16'h8001, 1'b0, 16'h0000, 1'b1);
        cmd_valid = 1'b0;
        wait_done();
        send(1'b1, 5'h07, 5'h1B, 16'h0000, 1'b1, 16'hC0DE, 1'b1);
        cmd_valid = 1'b0;
        wait_done();
        send(1'b0, 5'h08, 5'h1C, 16'h7E7E, 1'b0, 16'h0000, 1'b0);
        cmd_valid = 1'b0;
        wait_done();
`endif

        check_value("rsp_count", 64'(n_rsp), 64'(n_exp_rsp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
